mul_div_unit: RTL
=================

# mul_div_unit

Iterative signed multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the control unit and consumes its `ALUControl` codes 3'b110 (mult) and 3'b111 (div), plus the register-file operands. It produces HI/LO for mfhi/mflo writeback and a `busy` signal so the pipeline can stall. Each operation is a multi-cycle shift-add multiply or a restoring divide, one bit per clock.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request to begin an operation. Sampled on the rising edge.
- `alu_ctrl`, input, 3: operation select from the control unit. 3'b110 is mult, 3'b111 is div; all other codes are ignored.
- `a`, input, `WIDTH`: rs operand, signed; the dividend for div.
- `b`, input, `WIDTH`: rt operand, signed; the divisor for div.
- `rd_sel`, input, 1: read select. 1 selects HI (mfhi), 0 selects LO (mflo).
- `rd_data`, output, `WIDTH`: combinational read, `rd_sel ? hi : lo`.
- `hi`, output, `WIDTH`: HI register.
- `lo`, output, `WIDTH`: LO register.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse when HI/LO have just been updated.
- `div_by_zero`, output, 1: sticky flag, set by a div with `b == 0`.

## Operation
- FSM states are IDLE, CALC and FIX.
- **IDLE:**
  - A start is accepted when `start == 1` and `alu_ctrl` is 110 or 111.
  - On acceptance, latch the op and the signs of `a` and `b`, and load the magnitudes |a| and |b| as `WIDTH`-bit unsigned values (the most-negative value maps to 2^(WIDTH-1)).
  - Clear `div_by_zero`, load the iteration counter with `WIDTH-1`, and go to CALC.
  - In any other case, remain in IDLE.
- **CALC (mult):** shift-add over a 2·`WIDTH` product register. Each cycle: if the product LSB is 1, add |a| into the upper half with `WIDTH+1`-bit carry, then shift the whole register right by 1.
- **CALC (div):** restoring division with a `WIDTH+1`-bit partial remainder. Each cycle:
  - Shift the next dividend bit in.
  - Trial-subtract |b|.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
- **CALC exit:** when the counter reaches 0, go to FIX. The counter decrements once per CALC cycle, so CALC lasts exactly `WIDTH` cycles.
- **FIX (mult):** `{hi, lo}` = the product, two's-complement negated over 2·`WIDTH` bits if the sign of `a` differs from the sign of `b`.
- **FIX (div):**
  - `lo` = quotient, negated if the signs of `a` and `b` differ.
  - `hi` = remainder, negated if `a` is negative (the remainder takes the sign of the dividend).
  - Results are truncated to `WIDTH` bits, so 0x80000000 / -1 gives `lo` = 0x80000000 and `hi` = 0.
- **FIX (div by zero):** if the op is div and the latched `b == 0`, then `hi` = `a`, `lo` = all ones, and `div_by_zero` is set to 1. The latency is unchanged.
- **FIX exit:** FIX writes `hi`/`lo`, pulses `done`, and returns to IDLE.
- `busy` = (state != IDLE).
- A `start` while busy is ignored. There is no queueing, and the in-flight operation is unaffected.
- `rd_data` and `hi`/`lo` hold the previous results until the FIX edge. There is no forwarding of in-flight results.

## Timing
- **Reset** (asynchronous, `rst_n` = 0):
  - State goes to IDLE.
  - `hi` = `lo` = 0; `busy` = `done` = `div_by_zero` = 0.
  - Reset mid-operation aborts immediately, and HI/LO are zeroed.
- **Latency:** a start accepted at edge E0 puts CALC on edges E1 to E`WIDTH`; FIX executes on edge E`WIDTH+1`.
  - With `WIDTH` = 32, HI/LO update and `done` rises on E33.
  - `done` is high for exactly the one cycle after E33.
- **busy:** high in the cycles after E0 through E32, and low after E33.
- **Back-to-back:** a new start can be accepted on E34, which is the cycle in which `done` is high.
- `div_by_zero` remains valid until the next accepted start clears it.

## Test plan
- **Mult, small signed:** mult a=7, b=-3 -> `busy` 1 for 33 cycles, then `done` pulses once; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- **Mult, corner:** mult a=0x80000000, b=0x80000000 -> `hi` = 0x40000000, `lo` = 0x00000000.
- **Div, signed:**
  - div a=-7, b=2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - div a=0x80000000, b=-1 -> `lo` = 0x80000000, `hi` = 0.
- **Div by zero:** div a=5, b=0 -> `done` on E33; `hi` = 5, `lo` = 0xFFFFFFFF, `div_by_zero` = 1; a following mult clears the flag on acceptance.
- **Ignored requests and stale reads:**
  - A start at cycle 10 of a running op, and a start with `alu_ctrl` = 3'b000 while idle -> both ignored, and the original result is unchanged.
  - `rd_data` returns the old HI/LO until E33.
- **Async reset mid-op:** deassert then assert `rst_n` at cycle 12 of a div -> `busy`, `done`, `hi` and `lo` all go to 0 immediately; no `done` pulse follows.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// Shift-add multiply or restoring divide, one bit per clock, WIDTH+2 cycles per op.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]  OP_MULT = 3'b110;
    localparam logic [2:0]  OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic             op_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc;   // product upper half (mult) / partial remainder (div)
    logic [WIDTH-1:0] low;   // product lower half (mult) / dividend-quotient shifter (div)
    logic [CNT_W-1:0] cnt;

    logic                 accept_c;
    logic [WIDTH-1:0]     abs_a_c;
    logic [WIDTH-1:0]     abs_b_c;
    logic [WIDTH:0]       mul_sum_c;
    logic [WIDTH:0]       div_shift_c;
    logic [WIDTH:0]       div_diff_c;
    logic [2*WIDTH-1:0]   prod_c;
    logic [2*WIDTH-1:0]   prod_fix_c;
    logic [WIDTH-1:0]     quo_fix_c;
    logic [WIDTH-1:0]     rem_fix_c;
    logic [WIDTH-1:0]     a_orig_c;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) naturally
    assign abs_a_c = a[WIDTH-1] ? -a : a;
    assign abs_b_c = b[WIDTH-1] ? -b : b;

    // One multiply step: conditional add into the upper half with carry out
    assign mul_sum_c = {1'b0, acc} + (low[0] ? {1'b0, mag_a} : '0);

    // One restoring-divide step: shift next dividend bit in, trial-subtract
    assign div_shift_c = {acc, low[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, mag_b};

    // Sign correction applied on the FIX edge
    assign prod_c     = {acc, low};
    assign prod_fix_c = (sign_a ^ sign_b) ? -prod_c : prod_c;
    assign quo_fix_c  = (sign_a ^ sign_b) ? -low : low;
    assign rem_fix_c  = sign_a ? -acc : acc;
    assign a_orig_c   = sign_a ? -mag_a : mag_a;

    assign rd_data = rd_sel ? hi : lo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and start acceptance
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (alu_ctrl == OP_MULT || alu_ctrl == OP_DIV)) begin
                    accept_c   = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath, result registers and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            low         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        op_div      <= alu_ctrl[0];
                        sign_a      <= a[WIDTH-1];
                        sign_b      <= b[WIDTH-1];
                        mag_a       <= abs_a_c;
                        mag_b       <= abs_b_c;
                        acc         <= '0;
                        low         <= alu_ctrl[0] ? abs_a_c : abs_b_c;
                        cnt         <= CNT_W'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (op_div) begin
                        if (!div_diff_c[WIDTH]) begin
                            acc <= div_diff_c[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift_c[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum_c[WIDTH:1];
                        low <= {mul_sum_c[0], low[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!op_div) begin
                        hi <= prod_fix_c[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_c[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        hi          <= a_orig_c;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix_c;
                        lo <= quo_fix_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
